// File: rtl/bbox_overlay_writer.sv
// Bounding-box overlay writer.
// Requests a bounding box from the colour filter over a start/done/ack
// handshake, latches and clamps the result, then writes a one-pixel
// rectangle outline of it into the RGB444 frame buffer, one pixel per cycle.
module bbox_overlay_writer #(
  parameter int          H_RES     = 320,
  parameter int          V_RES     = 240,
  parameter logic [11:0] BOX_COLOR = 12'h0F0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        filt_done,
  input  logic [8:0]  x_min,
  input  logic [8:0]  x_max,
  input  logic [8:0]  y_min,
  input  logic [8:0]  y_max,
  output logic        filt_start,
  output logic        filt_ack,
  output logic [16:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        wr_en,
  output logic        box_valid,
  output logic        busy,
  output logic [7:0]  frame_count
);

  localparam logic [8:0]  X_LAST = 9'(H_RES - 1);
  localparam logic [8:0]  Y_LAST = 9'(V_RES - 1);
  localparam logic [16:0] ROW    = 17'(H_RES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE,
    S_ACK,
    S_CHECK,
    S_TOP,
    S_BOTTOM,
    S_LEFT,
    S_RIGHT,
    S_FINISH
  } state_t;

  state_t      state;
  logic [8:0]  bx_min, bx_max, by_min, by_max;
  logic [8:0]  cur;
  logic [8:0]  cx_min, cx_max, cy_min, cy_max;
  logic        box_empty;

  // Saturate a coordinate to the last valid column/row.
  function automatic logic [8:0] clamp(input logic [8:0] v, input logic [8:0] lim);
    clamp = (v > lim) ? lim : v;
  endfunction

  // Linear frame-buffer address of pixel (x, y).
  function automatic logic [16:0] pix_addr(input logic [8:0] x, input logic [8:0] y);
    pix_addr = 17'(y) * ROW + 17'(x);
  endfunction

  // Clamped view of the raw latched box; only consumed in CHECK.
  assign cx_min    = clamp(bx_min, X_LAST);
  assign cx_max    = clamp(bx_max, X_LAST);
  assign cy_min    = clamp(by_min, Y_LAST);
  assign cy_max    = clamp(by_max, Y_LAST);
  assign box_empty = (cx_min > cx_max) || (cy_min > cy_max);

  // Busy is decoded purely from the registered state.
  assign busy = (state != S_IDLE);

  // Control FSM with registered handshake and write-port outputs.
  // After CHECK the box registers hold clamped values, so the draw states
  // compare the edge cursor directly against them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      filt_start  <= 1'b0;
      filt_ack    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      wr_en       <= 1'b0;
      box_valid   <= 1'b0;
      frame_count <= '0;
      bx_min      <= '0;
      bx_max      <= '0;
      by_min      <= '0;
      by_max      <= '0;
      cur         <= '0;
    end else begin
      filt_start <= 1'b0;
      filt_ack   <= 1'b0;
      case (state)
        S_IDLE: begin
          // A lingering done from the previous frame blocks the next start.
          if (run && !filt_done) begin
            state      <= S_START;
            filt_start <= 1'b1;
          end
        end
        S_START: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (filt_done) begin
            state    <= S_ACK;
            filt_ack <= 1'b1;
          end
        end
        S_ACK: begin
          // The filter's box registers settle during its first done cycle,
          // so the box is taken at the end of ACK rather than on done.
          bx_min <= x_min;
          bx_max <= x_max;
          by_min <= y_min;
          by_max <= y_max;
          state  <= S_CHECK;
        end
        S_CHECK: begin
          bx_min <= cx_min;
          bx_max <= cx_max;
          by_min <= cy_min;
          by_max <= cy_max;
          if (box_empty) begin
            box_valid <= 1'b0;
            state     <= S_FINISH;
          end else begin
            box_valid <= 1'b1;
            state     <= S_TOP;
            cur       <= cx_min;
            wr_en     <= 1'b1;
            wr_data   <= BOX_COLOR;
            wr_addr   <= pix_addr(cx_min, cy_min);
          end
        end
        S_TOP: begin
          if (cur == bx_max) begin
            state   <= S_BOTTOM;
            cur     <= bx_min;
            wr_addr <= pix_addr(bx_min, by_max);
          end else begin
            cur     <= cur + 9'd1;
            wr_addr <= wr_addr + 17'd1;
          end
        end
        S_BOTTOM: begin
          if (cur == bx_max) begin
            state   <= S_LEFT;
            cur     <= by_min;
            wr_addr <= pix_addr(bx_min, by_min);
          end else begin
            cur     <= cur + 9'd1;
            wr_addr <= wr_addr + 17'd1;
          end
        end
        S_LEFT: begin
          if (cur == by_max) begin
            state   <= S_RIGHT;
            cur     <= by_min;
            wr_addr <= pix_addr(bx_max, by_min);
          end else begin
            cur     <= cur + 9'd1;
            wr_addr <= wr_addr + ROW;
          end
        end
        S_RIGHT: begin
          if (cur == by_max) begin
            state   <= S_FINISH;
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
          end else begin
            cur     <= cur + 9'd1;
            wr_addr <= wr_addr + ROW;
          end
        end
        S_FINISH: begin
          frame_count <= frame_count + 8'd1;
          if (run && !filt_done) begin
            state      <= S_START;
            filt_start <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bbox_overlay_writer.md
Name: bbox_overlay_writer

Overview:
- Initiator and consumer for the colour filter's start/done/ack handshake.
- Each frame, it requests a bounding-box computation, waits for the result, acknowledges it and latches the box.
- It then writes a one-pixel rectangle outline of the box into the 320x240, 12-bit RGB444 frame buffer through its write port.
- Sits between the filter and the frame-buffer write arbiter; it is the writer-side counterpart of the filter's read-only pixel scan.

Parameters:
- H_RES, 320, frame width in pixels; row stride of the write address.
- V_RES, 240, frame height in pixels.
- BOX_COLOR, 12'h0F0, RGB444 value written for every outline pixel.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level enable; while high, frames are processed back to back.
- filt_done  in  1  filter done flag; held high until acknowledged.
- x_min  in  9  filter bounding-box left column.
- x_max  in  9  filter bounding-box right column.
- y_min  in  9  filter bounding-box top row.
- y_max  in  9  filter bounding-box bottom row.
- filt_start  out  1  one-cycle start request to the filter.
- filt_ack  out  1  one-cycle acknowledge to the filter.
- wr_addr  out  17  frame-buffer write address, y*H_RES + x.
- wr_data  out  12  pixel data; BOX_COLOR when wr_en, else 0.
- wr_en  out  1  write strobe; one pixel per cycle.
- box_valid  out  1  last latched box was non-empty.
- busy  out  1  high whenever the state is not IDLE.
- frame_count  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; latched box registers 0; edge counters 0.
- Reset mid-draw aborts the draw immediately, with no further writes.
- All outputs are registered or decoded from registered state only; no combinational paths from inputs to outputs.
- States and transitions:
  - IDLE: run=1 -> START.
  - START: filt_start=1 for exactly this cycle -> WAIT_DONE.
  - WAIT_DONE: filt_done=1 -> ACK; otherwise stay.
  - ACK: filt_ack=1 for exactly this cycle. The box inputs are sampled on the edge ending ACK, one cycle after filt_done is first seen, because the filter updates its box registers during its first done cycle. -> CHECK.
  - CHECK: clamp and validate (rules below). Empty box -> FINISH with box_valid=0. Otherwise box_valid=1 -> TOP.
  - TOP: write (x, y_min) for x = x_min..x_max, one per cycle -> BOTTOM.
  - BOTTOM: write (x, y_max) for x = x_min..x_max -> LEFT.
  - LEFT: write (x_min, y) for y = y_min..y_max -> RIGHT.
  - RIGHT: write (x_max, y) for y = y_min..y_max -> FINISH.
  - FINISH: frame_count += 1. run=1 -> START; run=0 -> IDLE.
- Clamping in CHECK: any latched x value > H_RES-1 becomes H_RES-1; any y value > V_RES-1 becomes V_RES-1.
- Validity in CHECK: the box is empty if x_min > x_max or y_min > y_max. The filter's no-match result (319,0,239,0) is empty.
- Write count: exactly 2*(x_max-x_min+1) + 2*(y_max-y_min+1).
- Corner pixels are written twice; this is intentional and harmless.
- Address arithmetic: y*H_RES + x computed in 17 bits; maximum 76799, no overflow.
- Write timing: wr_en is high on every draw-state cycle and never outside the draw states. wr_addr and wr_data are valid in the same cycle as wr_en.
- run dropping mid-frame: the current frame completes fully, including the draw, then the block returns to IDLE.
- filt_start is never asserted while filt_done is high.
- A filt_done pulse arriving outside WAIT_DONE is ignored.
- Latency:
  - run rising in IDLE -> filt_start high on the next cycle.
  - filt_done high -> filt_ack high on the next cycle.
  - First write occurs 2 cycles after ACK.

Test Plan:
- Box (x_min=10, x_max=12, y_min=20, y_max=21) -> exactly 10 writes:
  - TOP: 6410, 6411, 6412
  - BOTTOM: 6730, 6731, 6732
  - LEFT: 6410, 6730
  - RIGHT: 6412, 6732
  - All with wr_data=12'h0F0; then frame_count=1.
- No-match box (319, 0, 239, 0) -> filt_ack pulses once, zero writes, box_valid=0, frame_count increments.
- Single pixel (5,5,5,5) -> 4 writes, all to address 1605; box_valid=1.
- Out-of-range box (x_min=300, x_max=400, y_min=230, y_max=250):
  - Clamped to x_max=319, y_max=239.
  - Writes: 2*20 + 2*10 = 60.
  - Max address 76799.
- Handshake timing: filter model holds filt_done for 5 cycles until ack -> filt_start is a single-cycle pulse, filt_ack is a single-cycle pulse exactly 1 cycle after filt_done rises, and no second start occurs while filt_done=1.
- Reset and run behaviour:
  - Async reset asserted mid-TOP -> wr_en, busy, frame_count and all other outputs drop to 0 immediately; after release the block stays in IDLE until run=1.
  - run held high for 3 frames -> frame_count=3 with back-to-back START pulses.
